// File: rtl/sync_fifo_vr.sv
// Single-clock valid/ready FIFO with occupancy count and almost-full/almost-empty flags.
// Defining SYNC_FIFO_PEAK_EN adds a peak_count port holding the high-water mark of count.
module sync_fifo_vr #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
`ifdef SYNC_FIFO_PEAK_EN
    ,
    output logic [CNT_W-1:0]  peak_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_w, empty_w;
    logic             push, pop;

    // Status decodes only from the count register, so no input reaches an output combinationally.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    assign push = s_valid & ~full_w;
    assign pop  = m_ready & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    assign m_data       = mem[rd_ptr_q];
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign s_ready      = ~full_w;
    assign m_valid      = ~empty_w;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

`ifdef SYNC_FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Randomised and directed bench for sync_fifo_vr, checked every cycle against a queue model.
module tb_sync_fifo_vr;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int AFULL_LVL  = DEPTH - 2;
    localparam int AEMPTY_LVL = 1;
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  count;
    logic              full, empty, almost_full, almost_empty;
`ifdef SYNC_FIFO_PEAK_EN
    logic [CNT_W-1:0]  peak_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [DATA_W-1:0] mq[$];
    int                mpeak = 0;

    sync_fifo_vr #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef SYNC_FIFO_PEAK_EN
        , .peak_count(peak_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a queue advanced on each rising edge from the rules for push/pop.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mpeak = 0;
        end else begin
            bit do_push, do_pop;
            do_push = s_valid && (mq.size() < DEPTH);
            do_pop  = m_ready && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(s_data);
            if (mq.size() > mpeak) mpeak = mq.size();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = mq.size();
            chk("count", int'(count), n);
            chk("full", int'(full), int'(n == DEPTH));
            chk("empty", int'(empty), int'(n == 0));
            chk("s_ready", int'(s_ready), int'(n != DEPTH));
            chk("m_valid", int'(m_valid), int'(n != 0));
            chk("almost_full", int'(almost_full), int'(n >= AFULL_LVL));
            chk("almost_empty", int'(almost_empty), int'(n <= AEMPTY_LVL));
            if (n > 0) chk("m_data", int'(m_data), int'(mq[0]));
`ifdef SYNC_FIFO_PEAK_EN
            chk("peak_count", int'(peak_count), mpeak);
`endif
        end
    end

    // Drive inputs just after a falling edge, then wait through one rising edge.
    task automatic step(input bit sv, input logic [DATA_W-1:0] sd, input bit mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        @(negedge clk);
        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_s_ready", int'(s_ready), 1);

        // Three pushes, then three pops with literal data.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("lit_count3", int'(count), 3);
        chk("lit_empty0", int'(empty), 0);
        chk("lit_head11", int'(m_data), 8'h11);
        step(1'b0, '0, 1'b1);
        chk("lit_head22", int'(m_data), 8'h22);
        step(1'b0, '0, 1'b1);
        chk("lit_head33", int'(m_data), 8'h33);
        step(1'b0, '0, 1'b1);
        chk("lit_empty1", int'(empty), 1);

        // Fill to full and attempt a 17th write.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
            if (i == 12) chk("lit_afull_at13", int'(almost_full), 0);
            if (i == 13) chk("lit_afull_at14", int'(almost_full), 1);
        end
        chk("lit_full", int'(full), 1);
        chk("lit_s_ready_full", int'(s_ready), 0);
        step(1'b1, 8'hEE, 1'b0);
        chk("lit_count_17th", int'(count), 16);

        // Full with simultaneous valid/ready: pop only, then push.
        step(1'b1, 8'hA5, 1'b1);
        chk("lit_count15", int'(count), 15);
        step(1'b1, 8'hA6, 1'b0);
        chk("lit_count16", int'(count), 16);

        // Drain to 5, then stream 40 words through at constant level.
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1);
        chk("lit_count5", int'(count), 5);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b1);
        chk("lit_stream_count5", int'(count), 5);

        // Random traffic in phases biased towards filling, draining and balance.
        for (int ph = 0; ph < 12; ph++) begin
            int pv, pr;
            pv = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
            pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 150; i++) begin
                d = 8'($urandom_range(0, 255));
                step($urandom_range(0, 99) < pv, d, $urandom_range(0, 99) < pr);
            end
        end

        // Reset in mid-flight with a push and pop pending.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        chk("lit_count10", int'(count), 10);
        rst = 1'b1;
        step(1'b1, 8'hFF, 1'b1);
        rst = 1'b0;
        chk("lit_rst_count", int'(count), 0);
        chk("lit_rst_empty", int'(empty), 1);
        chk("lit_rst_s_ready", int'(s_ready), 1);
`ifdef SYNC_FIFO_PEAK_EN
        chk("lit_rst_peak", int'(peak_count), 0);
`endif

        // High-water mark: fill to 9, drain to 2, refill to 6.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1);
`ifdef SYNC_FIFO_PEAK_EN
            chk("lit_peak_drain", int'(peak_count), 9);
`endif
        end
        chk("lit_count2", int'(count), 2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0);
`ifdef SYNC_FIFO_PEAK_EN
            chk("lit_peak_refill", int'(peak_count), 9);
`endif
        end
        chk("lit_count6", int'(count), 6);

        step(1'b0, '0, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_vr.md
# sync_fifo_vr

Parametrised single-clock FIFO with valid/ready handshakes on both sides, occupancy count and programmable almost-full/almost-empty flags. It is the standard decoupling buffer between producer and consumer blocks in the design. It replaces ad-hoc fixed-size buffers with one width- and depth-configurable block.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 16, entries; power of two, ≥2
- AFULL_LVL, DEPTH-2, almost_full asserts when count ≥ this (1..DEPTH)
- AEMPTY_LVL, 1, almost_empty asserts when count ≤ this (0..DEPTH-1)
- CNT_W, $clog2(DEPTH)+1, derived local width of count; not overridable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  producer offers s_data
- s_ready  out  1  FIFO can accept; = !full
- s_data  in  DATA_W  write payload
- m_valid  out  1  head entry valid; = !empty
- m_ready  in  1  consumer takes head
- m_data  out  DATA_W  head entry, show-ahead
- count  out  CNT_W  current occupancy 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- almost_empty  out  1  count ≤ AEMPTY_LVL
- peak_count  out  CNT_W  only with SYNC_FIFO_PEAK_EN; see Configuration

## Operation
- Push = s_valid & s_ready; pop = m_valid & m_ready; both evaluated on the same edge.
- Storage: DEPTH × DATA_W array, write on push at wr_ptr; not reset.
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits; each increments by 1 on its event and wraps DEPTH-1 → 0 naturally.
- count: +1 on push only, −1 on pop only, unchanged on push+pop or neither. count never exceeds DEPTH or underflows.
- Full: s_ready=0, push impossible; pop with s_valid=1 frees a slot visible next cycle only (no same-cycle pass-through of writes into a full FIFO).
- Empty: m_valid=0, pop impossible; a push with m_ready=1 is not bypassed to m_data in the same cycle.
- m_data = mem[rd_ptr] asynchronously (show-ahead); undefined and unchecked while m_valid=0.
- All status outputs (s_ready, m_valid, full, empty, almost_*) decode from the count register only: no combinational path from s_valid/m_ready to any output.
- Reset: wr_ptr=0, rd_ptr=0, count=0 → s_ready=1, m_valid=0, full=0, empty=1, almost_full=0 (AFULL_LVL≥1), almost_empty=1, peak_count=0. Reset mid-transfer discards all contents; push/pop in the reset cycle are ignored.

## Timing
- Write-to-read latency: 1 cycle. Entry pushed at edge N appears at m_data with m_valid=1 after edge N.
- Throughput: 1 push and 1 pop per cycle sustained, any fill level 1..DEPTH-1.
- Flags update on the edge after the causing push/pop, same edge as count.
- After rst deasserts, first push accepted on the first following edge.

## Configuration
- SYNC_FIFO_PEAK_EN defined: peak_count port exists; register updates to count_next when count_next > peak_count; reset clears to 0; never decreases otherwise.
- Not defined: peak_count port and register absent; all other behaviour identical.

## Test plan
- Reset, then push 0x11,0x22,0x33 with m_ready=0 -> count=3, empty=0, m_data=0x11; then m_ready=1 three cycles -> out 0x11,0x22,0x33, empty=1 after third pop.
- DEPTH=16: push 16 words with m_ready=0 -> full=1, s_ready=0 at count=16, 17th s_valid not accepted, almost_full=1 from count=14.
- Full FIFO, s_valid=1 and m_ready=1 for one cycle -> pop only, count=15; next cycle push accepted, count=16.
- Fill level 5, s_valid=m_ready=1 for 40 cycles with incrementing data -> count stays 5, ordering preserved across ≥2 pointer wraps.
- Fill to 10, assert rst one cycle with s_valid=m_ready=1 -> count=0, empty=1, s_ready=1, peak_count=0 (with SYNC_FIFO_PEAK_EN).
- SYNC_FIFO_PEAK_EN: fill to 9, drain to 2, fill to 6 -> peak_count=9 throughout drain and refill.
